// File: rtl/mm_operand_fetch.sv
// mm_operand_fetch
//   Operand fetch sequencer for the matrix-multiply datapath. On a start
//   handshake it reads the dimension headers from the input (A) and weight (B)
//   SRAMs and checks them. It then streams operand pairs A[i][k], B[k][j] to
//   the FP MAC stage in dot-product order (for i, for j, for k).
//
// Ports
//   clk, reset           : clock, synchronous active-high reset
//   start_valid/ready    : job request handshake (ready only when idle)
//   input_read_address   : A SRAM address, data returns one cycle later
//   input_read_data        on input_read_data
//   weight_read_address  : B SRAM address, data returns one cycle later
//   weight_read_data       on weight_read_data
//   op_valid/op_ready    : operand pair handshake towards the MAC
//   op_a, op_b           : A[i][k], B[k][j]
//   op_first, op_last    : k == 0, k == K-1 (op_last closes a result element)
//   op_row, op_col       : i, j of the result element being accumulated
//   dims_out             : {M, K, N} as read from the headers
//   dim_err              : header mismatch or zero dimension, held until next start
//   done                 : one-cycle pulse at job end (also on error)
module mm_operand_fetch #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DIM_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_valid,
  output logic                   start_ready,
  output logic [ADDR_WIDTH-1:0]  input_read_address,
  input  logic [DATA_WIDTH-1:0]  input_read_data,
  output logic [ADDR_WIDTH-1:0]  weight_read_address,
  input  logic [DATA_WIDTH-1:0]  weight_read_data,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [DATA_WIDTH-1:0]  op_a,
  output logic [DATA_WIDTH-1:0]  op_b,
  output logic                   op_first,
  output logic                   op_last,
  output logic [DIM_WIDTH-1:0]   op_row,
  output logic [DIM_WIDTH-1:0]   op_col,
  output logic [3*DIM_WIDTH-1:0] dims_out,
  output logic                   dim_err,
  output logic                   done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR_RD   = 3'd1;
  localparam logic [2:0] ST_HDR_WAIT = 3'd2;
  localparam logic [2:0] ST_CHECK    = 3'd3;
  localparam logic [2:0] ST_STREAM   = 3'd4;
  localparam logic [2:0] ST_DRAIN    = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic                  first;
    logic                  last;
    logic [DIM_WIDTH-1:0]  row;
    logic [DIM_WIDTH-1:0]  col;
  } pair_t;

  logic [2:0]            state;
  logic [DIM_WIDTH-1:0]  hdr_m, hdr_k, hdr_kw, hdr_n;
  logic [DIM_WIDTH-1:0]  idx_i, idx_j, idx_k;
  logic [ADDR_WIDTH-1:0] a_row_base, b_col_base;
  logic [ADDR_WIDTH-1:0] in_addr_p0, wt_addr_p0;
  logic [ADDR_WIDTH-1:0] k_step, n_step;

  logic                  vld_p1;
  logic                  first_p1, last_p1;
  logic [DIM_WIDTH-1:0]  row_p1, col_p1;

  pair_t                 skid0, skid1;
  logic [1:0]            buf_cnt;
  logic [1:0]            occ, cnt_after_pop;
  pair_t                 incoming, head;

  logic start_fire, hdr_bad, issue, last_issue;
  logic k_end, j_end, i_end;
  logic accept, pop, push, drain_done;

  assign k_step = ADDR_WIDTH'(hdr_k);
  assign n_step = ADDR_WIDTH'(hdr_n);

  assign start_ready = (state == ST_IDLE);
  assign start_fire  = start_valid && start_ready;
  assign done        = (state == ST_DONE);
  assign dims_out    = {hdr_m, hdr_k, hdr_n};
  assign hdr_bad     = (hdr_k != hdr_kw) || (hdr_m == '0) || (hdr_k == '0) || (hdr_n == '0);

  assign k_end = (idx_k == hdr_k - DIM_ONE);
  assign j_end = (idx_j == hdr_n - DIM_ONE);
  assign i_end = (idx_i == hdr_m - DIM_ONE);

  // In-flight read plus buffered pairs never exceed the two skid entries,
  // so a stall can always absorb the read already on its way back.
  assign occ        = buf_cnt + {1'b0, vld_p1};
  assign issue      = (state == ST_STREAM) && (occ < 2'd2);
  assign last_issue = issue && k_end && j_end && i_end;

  assign input_read_address  = in_addr_p0;
  assign weight_read_address = wt_addr_p0;

  // The SRAM word is bypassed straight to the MAC when the buffer is empty;
  // it is parked in the buffer only if the MAC does not take it this cycle.
  assign incoming = '{a: input_read_data, b: weight_read_data, first: first_p1,
                      last: last_p1, row: row_p1, col: col_p1};
  assign head     = (buf_cnt != 2'd0) ? skid0 : incoming;

  assign op_valid = (buf_cnt != 2'd0) || vld_p1;
  assign accept   = op_valid && op_ready;
  assign pop      = accept && (buf_cnt != 2'd0);
  assign push     = vld_p1 && !(accept && (buf_cnt == 2'd0));
  assign cnt_after_pop = buf_cnt - {1'b0, pop};
  assign drain_done    = (occ == 2'd0) || ((occ == 2'd1) && accept);

  assign op_a     = op_valid ? head.a     : '0;
  assign op_b     = op_valid ? head.b     : '0;
  assign op_first = op_valid ? head.first : 1'b0;
  assign op_last  = op_valid ? head.last  : 1'b0;
  assign op_row   = op_valid ? head.row   : '0;
  assign op_col   = op_valid ? head.col   : '0;

  // ---- stage p0: sequencer and read address generation ----
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      dim_err    <= 1'b0;
      hdr_m      <= '0;
      hdr_k      <= '0;
      hdr_kw     <= '0;
      hdr_n      <= '0;
      in_addr_p0 <= '0;
      wt_addr_p0 <= '0;
      vld_p1     <= 1'b0;
      buf_cnt    <= 2'd0;
    end else begin
      vld_p1  <= issue;
      buf_cnt <= cnt_after_pop + {1'b0, push};
      case (state)
        ST_IDLE: begin
          if (start_fire) begin
            state      <= ST_HDR_RD;
            dim_err    <= 1'b0;
            in_addr_p0 <= '0;
            wt_addr_p0 <= '0;
          end
        end
        ST_HDR_RD: state <= ST_HDR_WAIT;
        ST_HDR_WAIT: begin
          hdr_m  <= input_read_data[2*DIM_WIDTH-1:DIM_WIDTH];
          hdr_k  <= input_read_data[DIM_WIDTH-1:0];
          hdr_kw <= weight_read_data[2*DIM_WIDTH-1:DIM_WIDTH];
          hdr_n  <= weight_read_data[DIM_WIDTH-1:0];
          state  <= ST_CHECK;
        end
        ST_CHECK: begin
          if (hdr_bad) begin
            dim_err <= 1'b1;
            state   <= ST_DONE;
          end else begin
            in_addr_p0 <= ADDR_ONE;
            wt_addr_p0 <= ADDR_ONE;
            state      <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (issue) begin
            if (!k_end) begin
              in_addr_p0 <= in_addr_p0 + ADDR_ONE;
              wt_addr_p0 <= wt_addr_p0 + n_step;
            end else if (!j_end) begin
              // next column: same A row again, B restarts one column right
              in_addr_p0 <= a_row_base;
              wt_addr_p0 <= b_col_base + ADDR_ONE;
            end else begin
              in_addr_p0 <= a_row_base + k_step;
              wt_addr_p0 <= ADDR_ONE;
            end
            if (last_issue) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: if (drain_done) state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // ---- stage p0 -> p1: loop indices and tags of the read in flight ----
  always_ff @(posedge clk) begin
    if (state == ST_CHECK) begin
      idx_i      <= '0;
      idx_j      <= '0;
      idx_k      <= '0;
      a_row_base <= ADDR_ONE;
      b_col_base <= ADDR_ONE;
    end else if (issue) begin
      if (!k_end) begin
        idx_k <= idx_k + DIM_ONE;
      end else begin
        idx_k <= '0;
        if (!j_end) begin
          idx_j      <= idx_j + DIM_ONE;
          b_col_base <= b_col_base + ADDR_ONE;
        end else begin
          idx_j      <= '0;
          b_col_base <= ADDR_ONE;
          idx_i      <= idx_i + DIM_ONE;
          a_row_base <= a_row_base + k_step;
        end
      end
    end
    if (issue) begin
      first_p1 <= (idx_k == '0);
      last_p1  <= k_end;
      row_p1   <= idx_i;
      col_p1   <= idx_j;
    end
    // ---- stage p1 -> skid buffer ----
    if (pop) skid0 <= skid1;
    if (push) begin
      if (cnt_after_pop == 2'd0) skid0 <= incoming;
      else                       skid1 <= incoming;
    end
  end

endmodule

// File: tb/tb_mm_operand_fetch.sv
module tb_mm_operand_fetch;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        first;
    logic        last;
    logic [15:0] row;
    logic [15:0] col;
  } pair_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [11:0] input_read_address;
  logic [31:0] input_read_data;
  logic [11:0] weight_read_address;
  logic [31:0] weight_read_data;
  logic        op_valid;
  logic        op_ready;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        op_first;
  logic        op_last;
  logic [15:0] op_row;
  logic [15:0] op_col;
  logic [47:0] dims_out;
  logic        dim_err;
  logic        done;

  always #5 clk = ~clk;

  mm_operand_fetch #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DIM_WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .input_read_address(input_read_address), .input_read_data(input_read_data),
    .weight_read_address(weight_read_address), .weight_read_data(weight_read_data),
    .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .op_first(op_first), .op_last(op_last),
    .op_row(op_row), .op_col(op_col),
    .dims_out(dims_out), .dim_err(dim_err), .done(done)
  );

  // SRAM models: registered read, data one cycle after address
  logic [31:0] in_mem [0:4095];
  logic [31:0] wt_mem [0:4095];
  always @(posedge clk) begin
    input_read_data  <= in_mem[input_read_address];
    weight_read_data <= wt_mem[weight_read_address];
  end

  int    n_cmp = 0;
  int    n_bad = 0;
  pair_t obs_q[$];
  pair_t exp_q[$];
  int    first_valid_cyc, last_acc_cyc, done_cyc, done_cnt, valid_cnt;
  int    stall_cnt, stall_bad, timed_out;
  logic        done_err;
  logic [47:0] done_dims;

  task automatic load_job(input int m, input int k, input int kw, input int n);
    logic [31:0] r;
    for (int a = 0; a < 256; a++) begin
      in_mem[a] = '0;
      wt_mem[a] = '0;
    end
    in_mem[0] = {m[15:0], k[15:0]};
    wt_mem[0] = {kw[15:0], n[15:0]};
    for (int a = 1; a <= m * k; a++) begin
      r = $urandom();
      in_mem[a] = {r[31:12], 12'(a)};
    end
    for (int a = 1; a <= kw * n; a++) begin
      r = $urandom();
      wt_mem[a] = {r[31:12] ^ 20'hA5A5A, 12'(a)};
    end
  endtask

  // Reference: textbook triple loop over row-major matrices
  task automatic build_expected(input int m, input int k, input int n);
    pair_t p;
    exp_q.delete();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          p.a     = in_mem[1 + i * k + kk];
          p.b     = wt_mem[1 + kk * n + j];
          p.first = (kk == 0);
          p.last  = (kk == k - 1);
          p.row   = 16'(i);
          p.col   = 16'(j);
          exp_q.push_back(p);
        end
  endtask

  // Drives one job and records what the MAC side sees; cycle 1 is the
  // cycle right after the start transfer edge.
  task automatic run_job(input int ready_mode, input int stop_after);
    int    cyc, vc;
    bit    have_snap;
    pair_t snap, cur;
    bit    pat [6];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    obs_q.delete();
    first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1;
    done_cnt = 0; valid_cnt = 0; stall_cnt = 0; stall_bad = 0; timed_out = 0;
    done_err = 1'b0; done_dims = '0;
    @(negedge clk);
    start_valid = 1'b1;
    op_ready = 1'b0;
    cyc = 0;
    while (!start_ready) begin
      if (cyc >= 20) begin
        timed_out = 1;
        start_valid = 1'b0;
        return;
      end
      @(negedge clk);
      cyc++;
    end
    cyc = 0; vc = 0; have_snap = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start_valid = (cyc <= 3);  // held while busy: must be ignored
      cur = '{a: op_a, b: op_b, first: op_first, last: op_last, row: op_row, col: op_col};
      if (have_snap) begin
        stall_cnt++;
        if (!op_valid || cur !== snap) stall_bad++;
        have_snap = 0;
      end
      if (op_valid) begin
        valid_cnt++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin
          done_cyc  = cyc;
          done_err  = dim_err;
          done_dims = dims_out;
        end
      end
      if (done_cyc >= 0 && cyc >= done_cyc + 2) begin
        op_ready = 1'b0;
        break;
      end
      if (cyc > 400) begin
        timed_out = 1;
        op_ready = 1'b0;
        break;
      end
      if (ready_mode == 0) op_ready = 1'b1;
      else if (op_valid) begin
        op_ready = (vc < 6) ? pat[vc] : 1'($urandom_range(0, 1));
        vc++;
      end else op_ready = 1'($urandom_range(0, 1));
      if (op_valid && op_ready) begin
        obs_q.push_back(cur);
        last_acc_cyc = cyc;
        if (stop_after > 0 && obs_q.size() == stop_after) break;
      end else if (op_valid) begin
        have_snap = 1;
        snap = cur;
      end
    end
    start_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start_valid = 1'b0; op_ready = 1'b0;
    for (int a = 0; a < 4096; a++) begin
      in_mem[a] = '0;
      wt_mem[a] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (start_ready !== 1'b1) begin n_bad++; $display("FAIL reset_start_ready got %b want 1", start_ready); end
    n_cmp++;
    if (op_valid !== 1'b0 || done !== 1'b0 || dim_err !== 1'b0) begin
      n_bad++; $display("FAIL reset_flags got v=%b d=%b e=%b want 0 0 0", op_valid, done, dim_err);
    end
    n_cmp++;
    if (input_read_address !== 12'd0 || weight_read_address !== 12'd0) begin
      n_bad++; $display("FAIL reset_addr got %0d/%0d want 0/0", input_read_address, weight_read_address);
    end
    n_cmp++;
    if (dims_out !== 48'd0 || op_a !== 32'd0 || op_row !== 16'd0) begin
      n_bad++; $display("FAIL reset_data got dims=%h a=%h row=%0d want 0", dims_out, op_a, op_row);
    end
  endtask

  task automatic test_stream_basic();
    logic [11:0] lastvec;
    load_job(2, 3, 3, 2);
    build_expected(2, 3, 2);
    run_job(0, 0);
    n_cmp++;
    if (timed_out !== 0) begin n_bad++; $display("FAIL basic_timeout got %0d want 0", timed_out); end
    n_cmp++;
    if (obs_q.size() !== 12) begin n_bad++; $display("FAIL basic_count got %0d want 12", obs_q.size()); end
    for (int p = 0; p < exp_q.size(); p++) begin
      pair_t o;
      o = (p < obs_q.size()) ? obs_q[p] : '0;
      n_cmp++;
      if (o !== exp_q[p]) begin
        n_bad++;
        $display("FAIL basic_pair%0d got a=%h b=%h f=%b l=%b r=%0d c=%0d want a=%h b=%h f=%b l=%b r=%0d c=%0d",
                 p, o.a, o.b, o.first, o.last, o.row, o.col,
                 exp_q[p].a, exp_q[p].b, exp_q[p].first, exp_q[p].last, exp_q[p].row, exp_q[p].col);
      end
    end
    lastvec = '0;
    for (int p = 0; p < 12 && p < obs_q.size(); p++) lastvec[p] = obs_q[p].last;
    n_cmp++;
    if (lastvec !== 12'b1001_0010_0100) begin n_bad++; $display("FAIL basic_last_pos got %b want 100100100100", lastvec); end
    n_cmp++;
    if (obs_q.size() >= 6 && (obs_q[0].a !== in_mem[1] || obs_q[0].b !== wt_mem[1] ||
                              obs_q[5].a !== in_mem[3] || obs_q[5].b !== wt_mem[6])) begin
      n_bad++; $display("FAIL basic_addr got p0=%h/%h p5=%h/%h want %h/%h %h/%h", obs_q[0].a, obs_q[0].b,
                        obs_q[5].a, obs_q[5].b, in_mem[1], wt_mem[1], in_mem[3], wt_mem[6]);
    end
    n_cmp++;
    if (first_valid_cyc !== 5) begin n_bad++; $display("FAIL basic_latency got %0d want 5", first_valid_cyc); end
    n_cmp++;
    if (last_acc_cyc - first_valid_cyc !== 11) begin
      n_bad++; $display("FAIL basic_throughput got %0d want 11", last_acc_cyc - first_valid_cyc);
    end
    n_cmp++;
    if (done_cyc !== last_acc_cyc + 1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL basic_done got cyc=%0d cnt=%0d want cyc=%0d cnt=1", done_cyc, done_cnt, last_acc_cyc + 1);
    end
    n_cmp++;
    if (done_err !== 1'b0 || done_dims !== {16'd2, 16'd3, 16'd2}) begin
      n_bad++; $display("FAIL basic_dims got err=%b dims=%h want 0 000200030002", done_err, done_dims);
    end
  endtask

  task automatic test_stream_stall();
    load_job(2, 3, 3, 2);
    build_expected(2, 3, 2);
    run_job(1, 0);
    n_cmp++;
    if (timed_out !== 0 || obs_q.size() !== 12) begin
      n_bad++; $display("FAIL stall_count got %0d (timeout %0d) want 12", obs_q.size(), timed_out);
    end
    for (int p = 0; p < exp_q.size(); p++) begin
      pair_t o;
      o = (p < obs_q.size()) ? obs_q[p] : '0;
      n_cmp++;
      if (o !== exp_q[p]) begin
        n_bad++; $display("FAIL stall_pair%0d got a=%h b=%h r=%0d c=%0d want a=%h b=%h r=%0d c=%0d",
                          p, o.a, o.b, o.row, o.col, exp_q[p].a, exp_q[p].b, exp_q[p].row, exp_q[p].col);
      end
    end
    n_cmp++;
    if (stall_cnt < 1 || stall_bad !== 0) begin
      n_bad++; $display("FAIL stall_stable got %0d unstable of %0d stalls want 0 of >=1", stall_bad, stall_cnt);
    end
    n_cmp++;
    if (done_cyc !== last_acc_cyc + 1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL stall_done got cyc=%0d cnt=%0d want cyc=%0d cnt=1", done_cyc, done_cnt, last_acc_cyc + 1);
    end
  endtask

  task automatic test_dim_mismatch();
    load_job(2, 3, 4, 2);
    run_job(0, 0);
    n_cmp++;
    if (done_cyc !== 3 + 1 || done_cnt !== 1) begin
      n_bad++; $display("FAIL mismatch_done got cyc=%0d cnt=%0d want cyc=4 cnt=1", done_cyc, done_cnt);
    end
    n_cmp++;
    if (done_err !== 1'b1 || valid_cnt !== 0) begin
      n_bad++; $display("FAIL mismatch_err got err=%b valids=%0d want 1 0", done_err, valid_cnt);
    end
    n_cmp++;
    if (dim_err !== 1'b1 || start_ready !== 1'b1) begin
      n_bad++; $display("FAIL mismatch_hold got err=%b ready=%b want 1 1", dim_err, start_ready);
    end
  endtask

  task automatic test_unit_dims();
    load_job(1, 1, 1, 1);
    in_mem[1] = 32'h3F80_0000;
    wt_mem[1] = 32'h4000_0000;
    run_job(0, 0);
    n_cmp++;
    if (obs_q.size() !== 1) begin n_bad++; $display("FAIL unit_count got %0d want 1", obs_q.size()); end
    n_cmp++;
    if (obs_q.size() >= 1 && obs_q[0] !== '{a: 32'h3F80_0000, b: 32'h4000_0000, first: 1'b1, last: 1'b1,
                                          row: 16'd0, col: 16'd0}) begin
      n_bad++; $display("FAIL unit_pair got a=%h b=%h f=%b l=%b want 3f800000 40000000 1 1",
                        obs_q[0].a, obs_q[0].b, obs_q[0].first, obs_q[0].last);
    end
    n_cmp++;
    if (done_cyc !== last_acc_cyc + 1 || first_valid_cyc !== 5 || done_err !== 1'b0) begin
      n_bad++; $display("FAIL unit_timing got first=%0d done=%0d err=%b want 5 %0d 0",
                        first_valid_cyc, done_cyc, done_err, last_acc_cyc + 1);
    end
  endtask

  task automatic test_random_dims();
    int m, k, n;
    for (int it = 0; it < 4; it++) begin
      m = (it == 0) ? 2 : $urandom_range(1, 3);
      k = (it == 0) ? 1 : $urandom_range(1, 4);
      n = (it == 0) ? 3 : $urandom_range(1, 3);
      load_job(m, k, k, n);
      build_expected(m, k, n);
      run_job(it % 2, 0);
      n_cmp++;
      if (timed_out !== 0 || obs_q !== exp_q) begin
        n_bad++; $display("FAIL random_job%0d %0dx%0dx%0d got %0d pairs (timeout %0d) want %0d matching",
                          it, m, k, n, obs_q.size(), timed_out, exp_q.size());
      end
      n_cmp++;
      if (stall_bad !== 0 || done_cnt !== 1 || done_cyc !== last_acc_cyc + 1) begin
        n_bad++; $display("FAIL random_done%0d got unstable=%0d done_cnt=%0d done=%0d want 0 1 %0d",
                          it, stall_bad, done_cnt, done_cyc, last_acc_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    load_job(2, 3, 3, 2);
    build_expected(2, 3, 2);
    run_job(0, 5);
    @(negedge clk);
    reset = 1'b1;
    op_ready = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (op_valid !== 1'b0 || start_ready !== 1'b1 || done !== 1'b0 || dim_err !== 1'b0) begin
      n_bad++; $display("FAIL midreset_ctrl got v=%b rdy=%b d=%b e=%b want 0 1 0 0", op_valid, start_ready, done, dim_err);
    end
    n_cmp++;
    if (input_read_address !== 12'd0 || weight_read_address !== 12'd0 || op_a !== 32'd0) begin
      n_bad++; $display("FAIL midreset_data got %0d/%0d a=%h want 0/0 0", input_read_address, weight_read_address, op_a);
    end
    reset = 1'b0;
    run_job(0, 0);
    n_cmp++;
    if (timed_out !== 0 || obs_q !== exp_q) begin
      n_bad++; $display("FAIL midreset_rerun got %0d pairs (timeout %0d) want 12 matching", obs_q.size(), timed_out);
    end
    n_cmp++;
    if (done_cnt !== 1 || done_err !== 1'b0) begin
      n_bad++; $display("FAIL midreset_done got cnt=%0d err=%b want 1 0", done_cnt, done_err);
    end
  endtask

  initial begin
    test_reset();
    test_stream_basic();
    test_stream_stall();
    test_dim_mismatch();
    test_unit_dims();
    test_random_dims();
    test_reset_mid_stream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got no completion want finish before 1000000");
    $fatal(1);
  end

endmodule
